cache_exerciser: RTL

Parametrised self-checking traffic generator for the cache's 32-bit word interface. It replaces the fixed read/write/increment loop with a write pass then a read-and-verify pass over a configurable address window, stride and data pattern. It counts mismatches, records the first failing word, detects a hung handshake with a timeout, and can loop continuously. It sits between board control (buttons/LEDs) and the cache, clocked on the memory controller's user clock; choosing WORD_COUNT × STRIDE larger than the cache forces evictions and write-backs.

---
 rtl/cache_exerciser.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cache_exerciser.sv
// cache_exerciser: write-then-verify traffic generator for a 32-bit word cache port,
// with mismatch counting, first-error capture, access timeout and continuous looping.
module cache_exerciser #(
  parameter int unsigned ADDRESS_BITWIDTH     = 32,
  parameter int unsigned START_ADDRESS        = 0,
  parameter int unsigned WORD_COUNT           = 4096,
  parameter int unsigned STRIDE               = 4,
  parameter int unsigned TIMEOUT_CYCLES       = 4096,
  parameter int unsigned ERROR_COUNT_BITWIDTH = 16,
  parameter int unsigned PASS_COUNT_BITWIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            continuous,
  input  logic [1:0]                      mode,
  output logic [ADDRESS_BITWIDTH-1:0]     address,
  output logic [31:0]                     data_in,
  output logic [3:0]                      write_enable,
  input  logic [31:0]                     data_out,
  input  logic                            data_out_ready,
  input  logic                            busy,
  output logic                            running,
  output logic                            done,
  output logic                            fault,
  output logic [ERROR_COUNT_BITWIDTH-1:0] error_count,
  output logic [PASS_COUNT_BITWIDTH-1:0]  pass_count,
  output logic [ADDRESS_BITWIDTH-1:0]     first_error_address,
  output logic [31:0]                     first_error_data
);
  localparam int AW = ADDRESS_BITWIDTH;
  localparam int EW = ERROR_COUNT_BITWIDTH;
  localparam int PW = PASS_COUNT_BITWIDTH;
  localparam int IW = WORD_COUNT > 1 ? $clog2(WORD_COUNT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] START_A = AW'(START_ADDRESS);
  localparam logic [AW-1:0] STRIDE_A = AW'(STRIDE);
  typedef enum logic [3:0] {
    IDLE, WR_ISSUE, WR_SETTLE, WR_WAIT, RD_ISSUE, RD_SETTLE, RD_WAIT, DONE, FAULT
  } state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic [4:0] bit_pos;
  logic [AW-1:0] cur_a, addr_q;
  logic [31:0] din_q, a32, pattern;
  logic [1:0] mode_q;
  logic [TW-1:0] timer;
  logic stop_q, idle_like, in_wait, exit_ok, last, stop_seen, mismatch, timed_out;
  always_comb begin
    a32 = 32'(cur_a);
    pattern = mode_q == 2'd0 ? a32 : mode_q == 2'd1 ? ~a32 : mode_q == 2'd2 ? 32'h1 << bit_pos : a32 + 32'(pass_count);
    idle_like = state inside {IDLE, DONE, FAULT};
    in_wait = state == WR_WAIT || state == RD_WAIT;
    exit_ok = !busy && (state == WR_WAIT || data_out_ready);
    last = idx == IW'(WORD_COUNT - 1);
    stop_seen = stop_q | stop;
    mismatch = state == RD_WAIT && exit_ok && data_out != pattern;
    timed_out = timer == TW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, FAULT: next = start ? WR_ISSUE : state;
      WR_ISSUE:  next = WR_SETTLE;
      WR_SETTLE: next = WR_WAIT;
      WR_WAIT:   next = exit_ok ? (stop_seen ? DONE : last ? RD_ISSUE : WR_ISSUE) : timed_out ? FAULT : WR_WAIT;
      RD_ISSUE:  next = RD_SETTLE;
      RD_SETTLE: next = RD_WAIT;
      RD_WAIT:   next = exit_ok ? (last ? (continuous && !stop_seen ? WR_ISSUE : DONE) : stop_seen ? DONE : RD_ISSUE)
                                : timed_out ? FAULT : RD_WAIT;
      default:   next = IDLE;
    endcase
  end
  // issue states present the fresh word; every other state holds the last issued one
  always_comb begin
    running = !idle_like;
    done = state == DONE;
    fault = state == FAULT;
    write_enable = state == WR_ISSUE ? 4'hF : 4'h0;
    address = state == WR_ISSUE || state == RD_ISSUE ? cur_a : addr_q;
    data_in = state == WR_ISSUE ? pattern : din_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      bit_pos <= '0;
      cur_a <= '0;
      addr_q <= '0;
      din_q <= '0;
      mode_q <= '0;
      stop_q <= 1'b0;
      timer <= '0;
      error_count <= '0;
      pass_count <= '0;
      first_error_address <= '0;
      first_error_data <= '0;
    end else if (idle_like && start) begin
      idx <= '0;
      bit_pos <= '0;
      cur_a <= START_A;
      mode_q <= mode;
      stop_q <= 1'b0;
      timer <= '0;
      error_count <= '0;
      pass_count <= '0;
      first_error_address <= '0;
      first_error_data <= '0;
    end else begin
      if (stop && running) stop_q <= 1'b1;
      timer <= in_wait ? timer + TW'(1) : '0;
      if (state == WR_ISSUE || state == RD_ISSUE) addr_q <= cur_a;
      if (state == WR_ISSUE) din_q <= pattern;
      if (mismatch) begin
        error_count <= &error_count ? error_count : error_count + EW'(1);
        if (error_count == '0) begin
          first_error_address <= cur_a;
          first_error_data <= data_out;
        end
      end
      if (in_wait && exit_ok) begin
        idx <= last ? '0 : idx + IW'(1);
        bit_pos <= last ? '0 : bit_pos + 5'd1;
        cur_a <= last ? START_A : cur_a + STRIDE_A;
        if (state == RD_WAIT && last) pass_count <= pass_count + PW'(1);
      end
    end
  end
endmodule
